pwm_ramp_ctrl: RTL and testbench
================================

// Module: pwm_ramp_ctrl
// PURPOSE
//  Soft-start / slew controller that sequences the duty input of the PWM generator.
//  Accepts a target-duty command over a valid/ready handshake.
//  Steps the applied duty toward the target by a fixed step every N PWM periods.
//  Duty changes only at period boundaries, so the PWM never sees a mid-period update.
//  Sits between the ui_in/config path and the PWM counter/comparator.
// PARAMETERS
//  DUTY_W  5  duty width; DUTY_MAX = 2**DUTY_W-1 = 31, matching the PWM period
//  STEP_W  3  width of per-update duty step
//  HOLD_W  8  width of dwell count, in PWM periods between steps
// PORTS
//  clk         in   1       single clock; all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  enable      in   1       0 = abort/disable: duty forced to 0, FSM to IDLE
//  period_end  in   1       1-cycle pulse from PWM counter at count==DUTY_MAX
//  cmd_valid   in   1       command present
//  cmd_ready   out  1       1 only in IDLE with enable=1; transfer = valid&ready
//  cmd_target  in   DUTY_W  target duty
//  cmd_step    in   STEP_W  duty step per update; 0 treated as 1
//  cmd_hold    in   HOLD_W  extra periods between steps; 0 = step every period
//  duty_out    out  DUTY_W  registered duty to PWM comparator
//  duty_upd    out  1       1-cycle pulse in the cycle duty_out changes
//  busy        out  1       1 while in RAMP
//  done        out  1       1-cycle pulse when duty_out reaches the target
// BEHAVIOUR
//  Reset: duty_out=0, duty_upd=0, busy=0, done=0, FSM=IDLE, dwell=0.
//  cmd_ready is combinational: (state==IDLE) & enable.
//  FSM states:
//   IDLE: on transfer, latch target/step(min 1)/hold, load dwell=hold.
//     If target==duty_out, pulse done next cycle and stay IDLE.
//     Otherwise go to RAMP.
//   RAMP: act only on period_end.
//     If dwell!=0, decrement dwell. Otherwise apply one step and reload dwell=hold.
//     Step up: duty_out = min(duty_out+step, target).
//     Step down: duty_out = max(duty_out-step, target).
//     Compute in DUTY_W+1 bits; no wrap past 0 or DUTY_MAX.
//     The step that lands on target pulses done the same cycle duty_out updates; FSM goes to IDLE.
//  Latency:
//   Transfer in cycle T, even with a coincident period_end, never steps in T.
//   The first step registers at the first period_end strictly after T, plus hold periods.
//   duty_out updates in the cycle after that period_end pulse is sampled (registered); duty_upd is high in that cycle.
//  busy=1 exactly while state==RAMP. No new command is accepted in RAMP (cmd_ready=0).
//  enable=0 (any state):
//   Next edge sets duty_out=0 and FSM=IDLE; the pending ramp is dropped.
//   duty_upd pulses if duty_out was nonzero. No done pulse.
//  enable 0->1 resumes from duty_out=0 in IDLE.
//  Async rst mid-ramp returns all outputs to reset values immediately.
//  period_end while IDLE is ignored; cmd_valid while not ready is held, not lost (source keeps valid).
// STRUCTURE
//  Package pwm_pkg:
//   DUTY_W default and DUTY_MAX constant
//   state enum {IDLE, RAMP} (2-bit encoding reserved for growth)
//  Sub-module duty_slew: combinational saturating step.
//   Inputs: cur, tgt, step. Outputs: nxt, at_tgt.
//   Reused by any future multi-channel sequencer.
//  Top holds the FSM, command latches, dwell counter and the duty_out register.
// TESTING
//  1. Reset, enable=1; cmd target=31 step=4 hold=0; period_end every 32 clk
//     -> duty 4,8,...,28,31 on 8 successive periods; done with the 31 update.
//  2. From 31: target=0 step=0(->1) hold=2 -> one decrement every 3rd period_end; 31 updates; no underflow.
//  3. cmd_valid and period_end in the same cycle -> no step that period; first step at the next period_end.
//  4. Mid-ramp at duty=12, drop enable -> next cycle duty_out=0, duty_upd=1, busy=0, done=0, cmd_ready=0 until enable returns.
//  5. cmd target equal to current duty -> accepted, done 1 cycle later, duty_upd never asserted.
//  6. Assert rst asynchronously mid-ramp -> all outputs 0 and cmd_ready=1 (enable=1) before the next edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, duty ceiling and ramp FSM state encoding
package pwm_pkg;
    localparam int DUTY_W_DEF = 5;
    localparam int STEP_W_DEF = 3;
    localparam int HOLD_W_DEF = 8;
    localparam int DUTY_MAX   = 2**DUTY_W_DEF - 1;
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1} state_t;
endpackage

// File: rtl/duty_slew.sv
// duty_slew: one saturating duty step from cur toward tgt, never overshooting or wrapping
module duty_slew #(
    parameter int DUTY_W = 5,
    parameter int STEP_W = 3
) (
    input  logic [DUTY_W-1:0] cur,
    input  logic [DUTY_W-1:0] tgt,
    input  logic [STEP_W-1:0] step,
    output logic [DUTY_W-1:0] nxt,
    output logic              at_tgt
);
    logic [DUTY_W:0] stp_x;
    logic [DUTY_W:0] up_sum;
    logic [DUTY_W:0] dn_dif;
    assign stp_x  = {{(DUTY_W+1-STEP_W){1'b0}}, step};
    assign up_sum = {1'b0, cur} + stp_x;
    assign dn_dif = {1'b0, cur} - stp_x;
    assign nxt    = (tgt > cur)
                  ? ((up_sum >= {1'b0, tgt}) ? tgt : up_sum[DUTY_W-1:0])
                  : ((dn_dif[DUTY_W] || dn_dif[DUTY_W-1:0] <= tgt) ? tgt : dn_dif[DUTY_W-1:0]);
    assign at_tgt = nxt == tgt;
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: slews the PWM duty toward a commanded target, updating only at period boundaries
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int STEP_W = STEP_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              period_end,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_upd,
    output logic              busy,
    output logic              done
);
    state_t            state, state_n;
    logic [DUTY_W-1:0] tgt_q;
    logic [STEP_W-1:0] step_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] dwell;
    logic [DUTY_W-1:0] nxt;
    logic              at_tgt;
    logic              xfer;
    logic              step_now;

    assign cmd_ready = (state == IDLE) && enable;
    assign busy      = state == RAMP;
    assign xfer      = cmd_valid && cmd_ready;
    assign step_now  = busy && period_end && dwell == '0;

    duty_slew #(.DUTY_W(DUTY_W), .STEP_W(STEP_W)) u_slew (
        .cur    (duty_out),
        .tgt    (tgt_q),
        .step   (step_q),
        .nxt    (nxt),
        .at_tgt (at_tgt)
    );

    // FSM next state: disable always wins, a matching target never enters RAMP
    always_comb begin
        state_n = !enable                                   ? IDLE
                : (state == IDLE && xfer && cmd_target != duty_out) ? RAMP
                : (step_now && at_tgt)                      ? IDLE
                : state;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // command latches, dwell countdown and the registered duty with its pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q    <= '0;
            step_q   <= '0;
            hold_q   <= '0;
            dwell    <= '0;
            duty_out <= '0;
            duty_upd <= 1'b0;
            done     <= 1'b0;
        end else begin
            duty_upd <= 1'b0;
            done     <= 1'b0;
            if (!enable) begin
                duty_out <= '0;
                duty_upd <= |duty_out;
                dwell    <= '0;
            end else if (xfer) begin
                tgt_q  <= cmd_target;
                step_q <= cmd_step | STEP_W'(cmd_step == '0);
                hold_q <= cmd_hold;
                dwell  <= cmd_hold;
                done   <= cmd_target == duty_out;
            end else if (busy && period_end) begin
                if (dwell != '0) begin
                    dwell <= dwell - 1'b1;
                end else begin
                    duty_out <= nxt;
                    duty_upd <= 1'b1;
                    done     <= at_tgt;
                    dwell    <= hold_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: scenario tasks checked against a target/step/hold arithmetic model
module tb_pwm_ramp_ctrl;
    import pwm_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       period_end = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] cmd_target = '0;
    logic [2:0] cmd_step = '0;
    logic [7:0] cmd_hold = '0;
    logic [4:0] duty_out;
    logic       duty_upd;
    logic       busy;
    logic       done;
    int total = 0;
    int bad = 0;
    int m_duty = 0;

    pwm_ramp_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .period_end (period_end),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_hold   (cmd_hold),
        .duty_out   (duty_out),
        .duty_upd   (duty_upd),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // issue one command and follow it for up to max_steps duty updates (max_steps<0: to completion)
    task automatic do_ramp(input int tgt, input int stp, input int hld, input int gap, input bit coinc, input int max_steps);
        int q[$];
        int cur, s, n, e;
        bit last;
        cur = m_duty;
        s = (stp == 0) ? 1 : stp;
        while (cur != tgt) begin
            cur = (tgt > cur) ? ((cur + s > tgt) ? tgt : cur + s) : ((cur - s < tgt) ? tgt : cur - s);
            q.push_back(cur);
        end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_before_cmd got=%b exp=1", cmd_ready); end
        cmd_target = 5'(tgt);
        cmd_step   = 3'(stp);
        cmd_hold   = 8'(hld);
        cmd_valid  = 1'b1;
        period_end = coinc;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        period_end = 1'b0;
        total++; if (duty_out !== 5'(m_duty) || duty_upd !== 1'b0) begin bad++; $display("FAIL no_step_on_accept duty=%0d upd=%b exp duty=%0d upd=0", duty_out, duty_upd, m_duty); end
        total++; if (busy !== (q.size() != 0) || done !== (q.size() == 0)) begin bad++; $display("FAIL accept_flags busy=%b done=%b exp busy=%b done=%b", busy, done, q.size() != 0, q.size() == 0); end
        if (q.size() == 0) begin
            repeat (3) begin
                @(posedge clk); #1;
                total++; if (done !== 1'b0 || duty_upd !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL equal_after done=%b upd=%b ready=%b exp 0 0 1", done, duty_upd, cmd_ready); end
            end
            return;
        end
        n = 0;
        while (q.size() != 0 && (max_steps < 0 || n < max_steps)) begin
            for (int p = 0; p <= hld; p++) begin
                repeat (gap - 1) begin @(posedge clk); #1; end
                total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL ramp_busy busy=%b ready=%b exp 1 0", busy, cmd_ready); end
                period_end = 1'b1;
                @(posedge clk); #1;
                period_end = 1'b0;
                if (p < hld) begin
                    total++; if (duty_upd !== 1'b0 || duty_out !== 5'(m_duty)) begin bad++; $display("FAIL dwell duty=%0d upd=%b exp duty=%0d upd=0", duty_out, duty_upd, m_duty); end
                end else begin
                    e = q.pop_front();
                    last = q.size() == 0;
                    total++; if (duty_out !== 5'(e) || duty_upd !== 1'b1 || done !== last) begin bad++; $display("FAIL step duty=%0d upd=%b done=%b exp duty=%0d upd=1 done=%b", duty_out, duty_upd, done, e, last); end
                    m_duty = e;
                end
            end
            n++;
        end
        if (q.size() == 0) begin
            total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL ramp_end busy=%b ready=%b exp 0 1", busy, cmd_ready); end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (duty_out !== 5'd0 || duty_upd !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_outputs duty=%0d upd=%b busy=%b done=%b exp all 0", duty_out, duty_upd, busy, done); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        rst = 1'b0;
        m_duty = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp_up();
        do_ramp(DUTY_MAX, 4, 0, 32, 1'b0, -1);
        total++; if (duty_out !== 5'd31) begin bad++; $display("FAIL ramp_up_final got=%0d exp=31", duty_out); end
    endtask

    task automatic test_ramp_down_hold();
        do_ramp(0, 0, 2, 4, 1'b0, -1);
        @(posedge clk); #1;
        total++; if (duty_out !== 5'd0 || duty_upd !== 1'b0) begin bad++; $display("FAIL no_underflow duty=%0d upd=%b exp 0 0", duty_out, duty_upd); end
    endtask

    task automatic test_abort();
        do_ramp(31, 4, 0, 5, 1'b0, 3);
        total++; if (duty_out !== 5'd12) begin bad++; $display("FAIL abort_setup got=%0d exp=12", duty_out); end
        enable = 1'b0;
        @(posedge clk); #1;
        total++; if (duty_out !== 5'd0 || duty_upd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin bad++; $display("FAIL abort duty=%0d upd=%b busy=%b done=%b ready=%b exp 0 1 0 0 0", duty_out, duty_upd, busy, done, cmd_ready); end
        m_duty = 0;
        for (int i = 0; i < 4; i++) begin
            period_end = i[0];
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            total++; if (duty_out !== 5'd0 || duty_upd !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin bad++; $display("FAIL disabled duty=%0d upd=%b busy=%b ready=%b exp 0 0 0 0", duty_out, duty_upd, busy, cmd_ready); end
        end
        cmd_valid = 1'b0;
        period_end = 1'b0;
        enable = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reenable_ready got=%b exp=1", cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_coincident();
        do_ramp(20, 5, 1, 3, 1'b1, -1);
    endtask

    task automatic test_equal_target();
        do_ramp(m_duty, 3, 4, 2, 1'b0, -1);
        total++; if (duty_out !== 5'(m_duty)) begin bad++; $display("FAIL equal_duty got=%0d exp=%0d", duty_out, m_duty); end
    endtask

    task automatic test_async_rst();
        do_ramp(31, 3, 0, 4, 1'b0, 2);
        period_end = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        total++; if (duty_out !== 5'd0 || duty_upd !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL async_rst duty=%0d upd=%b busy=%b done=%b ready=%b exp 0 0 0 0 1", duty_out, duty_upd, busy, done, cmd_ready); end
        period_end = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_duty = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            do_ramp(int'($urandom_range(0, 31)), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                    int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), -1);
            repeat (int'($urandom_range(0, 2))) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_ramp_up();
        test_ramp_down_hold();
        test_abort();
        test_coincident();
        test_equal_target();
        test_async_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
